// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and its run/stall/flush controller.
interface pipeline_ctrl_if #(
    parameter int unsigned NBITS = 32
);
    logic             i_mode_step;
    logic             i_start;
    logic             i_step;
    logic [4:0]       i_id_rs;
    logic [4:0]       i_id_rt;
    logic             i_ex_mem_read;
    logic [4:0]       i_ex_rt;
    logic             i_branch_taken;
    logic             i_halt_decoded;
    logic             o_pc_en;
    logic             o_if_id_en;
    logic             o_if_id_flush;
    logic             o_id_ex_bubble;
    logic             o_pipe_en;
    logic [1:0]       o_state;
    logic             o_done;
    logic [NBITS-1:0] o_cycle_count;

    // Datapath side: drives status, consumes enables.
    modport master (
        output i_mode_step, i_start, i_step, i_id_rs, i_id_rt, i_ex_mem_read, i_ex_rt,
               i_branch_taken, i_halt_decoded,
        input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_bubble, o_pipe_en, o_state,
               o_done, o_cycle_count
    );

    // Controller side.
    modport slave (
        input  i_mode_step, i_start, i_step, i_id_rs, i_id_rt, i_ex_mem_read, i_ex_rt,
               i_branch_taken, i_halt_decoded,
        output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_bubble, o_pipe_en, o_state,
               o_done, o_cycle_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline run controller: start/step sequencing, load-use stall, branch flush and
// HALT drain, with a saturating count of advance cycles in the current run.
module pipeline_ctrl #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned DRAIN = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    pipeline_ctrl_if.slave  bus
);
    localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             adv, hazard;

    assign adv     = !bus.i_mode_step | bus.i_step;
    assign hazard  = bus.i_ex_mem_read & (bus.i_ex_rt != 5'd0) &
                     ((bus.i_ex_rt == bus.i_id_rs) | (bus.i_ex_rt == bus.i_id_rt));
    assign cnt_inc = (cnt_q == {NBITS{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    assign bus.o_state       = state_q;
    assign bus.o_done        = (state_q == StDone);
    assign bus.o_cycle_count = cnt_q;

    // State, run counter and drain counter registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next-state and combinational pipeline enables.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        dcnt_d             = dcnt_q;
        bus.o_pc_en        = 1'b0;
        bus.o_if_id_en     = 1'b0;
        bus.o_if_id_flush  = 1'b0;
        bus.o_id_ex_bubble = 1'b0;
        bus.o_pipe_en      = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (bus.i_start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (adv) begin
                    bus.o_pipe_en = 1'b1;
                    cnt_d         = cnt_inc;
                    if (bus.i_branch_taken) begin
                        // Branch wins over stall and discards any HALT sitting in ID.
                        bus.o_pc_en       = 1'b1;
                        bus.o_if_id_en    = 1'b1;
                        bus.o_if_id_flush = 1'b1;
                    end else if (hazard) begin
                        bus.o_id_ex_bubble = 1'b1;
                    end else begin
                        bus.o_if_id_en = 1'b1;
                        if (bus.i_halt_decoded) begin
                            bus.o_if_id_flush = 1'b1;
                            state_d           = StDrain;
                            dcnt_d            = DRAIN_LOAD;
                        end else begin
                            bus.o_pc_en = 1'b1;
                        end
                    end
                end
            end
            StDrain: begin
                if (adv) begin
                    bus.o_if_id_en    = 1'b1;
                    bus.o_if_id_flush = 1'b1;
                    bus.o_pipe_en     = 1'b1;
                    cnt_d             = cnt_inc;
                    if (dcnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table walked from reset, plus hand-written
// sequences for runs, drain, step mode, asynchronous reset and counter saturation.
module tb_pipeline_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    pipeline_ctrl_if #(.NBITS(32)) bus ();
    pipeline_ctrl_if #(.NBITS(3))  bus_s ();

    pipeline_ctrl #(.NBITS(32), .DRAIN(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    pipeline_ctrl #(.NBITS(3), .DRAIN(1)) dut_s (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode, start, step, mr, br, halt;
        logic [4:0] rs, rt, ex_rt;
        logic [4:0] co;   // expected {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}
        logic [1:0] st;   // expected state after the edge
        int         cnt;  // expected cycle count after the edge
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic mode, input logic start, input logic step,
                          input logic mr, input logic br, input logic halt,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt);
        bus.i_mode_step    = mode;   bus_s.i_mode_step    = mode;
        bus.i_start        = start;  bus_s.i_start        = start;
        bus.i_step         = step;   bus_s.i_step         = step;
        bus.i_ex_mem_read  = mr;     bus_s.i_ex_mem_read  = mr;
        bus.i_branch_taken = br;     bus_s.i_branch_taken = br;
        bus.i_halt_decoded = halt;   bus_s.i_halt_decoded = halt;
        bus.i_id_rs        = rs;     bus_s.i_id_rs        = rs;
        bus.i_id_rt        = rt;     bus_s.i_id_rt        = rt;
        bus.i_ex_rt        = ex_rt;  bus_s.i_ex_rt        = ex_rt;
    endtask

    function automatic logic [4:0] comb_out();
        return {bus.o_pc_en, bus.o_if_id_en, bus.o_if_id_flush, bus.o_id_ex_bubble,
                bus.o_pipe_en};
    endfunction

    // Idle inputs, pulse reset across an edge, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One plain continuous-mode cycle with no hazard/branch/halt.
    task automatic run_cycle(input logic halt);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, halt, 0, 0, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pe_hits;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //             mode st stp mr br hlt rs  rt  ext  co        st cnt
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b00000,2'd0,0};
        vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b00000,2'd1,0};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd1,5'd2,5'd0,5'b11001,2'd1,1};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd5,5'd2,5'd5,5'b00011,2'd1,2};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,5'b11001,2'd1,3};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd3,5'd7,5'd7,5'b00011,2'd1,4};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd5,5'd0,5'd5,5'b11101,2'd1,5};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd0,5'd0,5'd0,5'b11101,2'd1,6};
        vt[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'd9,5'd0,5'd9,5'b00011,2'd1,7};
        vt[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b00000,2'd1,7};
        vt[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b00000,2'd1,7};
        vt[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b11001,2'd1,8};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd0,5'd0,5'd0,5'b01101,2'd2,9};
        vt[13] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd4,5'd0,5'd4,5'b01101,2'd2,10};
        vt[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b00000,2'd2,10};
        vt[15] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b01101,2'd2,11};
        vt[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b01101,2'd2,12};
        vt[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b01101,2'd3,13};
        vt[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b00000,2'd3,13};
        vt[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b00000,2'd1,0};
        vt[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,5'b11001,2'd1,1};

        // Reset state, held across an edge.
        @(posedge clk);
        #1;
        chk("reset_state", 64'(bus.o_state), 64'd0);
        chk("reset_count", 64'(bus.o_cycle_count), 64'd0);
        chk("reset_outs", 64'({comb_out(), bus.o_done}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Vector table walked from IDLE.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            set_in(vt[i].mode, vt[i].start, vt[i].step, vt[i].mr, vt[i].br, vt[i].halt,
                   vt[i].rs, vt[i].rt, vt[i].ex_rt);
            #1;
            chk($sformatf("vec%0d_outs", i), 64'(comb_out()), 64'(vt[i].co));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_state", i), 64'(bus.o_state), 64'(vt[i].st));
            chk($sformatf("vec%0d_count", i), 64'(bus.o_cycle_count), 64'(vt[i].cnt));
            chk($sformatf("vec%0d_done", i), 64'(bus.o_done), 64'(vt[i].st == 2'd3));
        end

        // Continuous run of 10 cycles, then HALT and a 4-cycle drain.
        do_reset();
        @(negedge clk);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("run_pc_en%0d", i), 64'(bus.o_pc_en), 64'd1);
            @(posedge clk);
        end
        #1;
        chk("run_count10", 64'(bus.o_cycle_count), 64'd10);
        run_cycle(1'b1);
        chk("halt_state", 64'(bus.o_state), 64'd2);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0);
            chk($sformatf("drain_state%0d", i), 64'(bus.o_state), (i < 3) ? 64'd2 : 64'd3);
        end
        chk("drain_done", 64'(bus.o_done), 64'd1);
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("done_frozen", 64'(bus.o_cycle_count), 64'd15);

        // Step mode: three step pulses over twenty cycles.
        do_reset();
        @(negedge clk);
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        pe_hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_in(1, 0, (i == 3 || i == 9 || i == 15), 0, 0, 0, 0, 0, 0);
            #1;
            if (bus.o_pipe_en) pe_hits++;
            @(posedge clk);
        end
        #1;
        chk("step_pipe_en_hits", 64'(pe_hits), 64'd3);
        chk("step_count", 64'(bus.o_cycle_count), 64'd3);

        // Asynchronous reset between edges while draining.
        do_reset();
        @(negedge clk);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        run_cycle(1'b0);
        run_cycle(1'b1);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_drain_outs", 64'(comb_out()), 64'b01101);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_state", 64'(bus.o_state), 64'd0);
        chk("async_rst_outs", 64'({comb_out(), bus.o_done}), 64'd0);
        chk("async_rst_count", 64'(bus.o_cycle_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("restart_state", 64'(bus.o_state), 64'd1);
        chk("restart_count", 64'(bus.o_cycle_count), 64'd0);
        run_cycle(1'b0);
        chk("restart_count1", 64'(bus.o_cycle_count), 64'd1);

        // Narrow counter saturates; single-cycle drain.
        do_reset();
        @(negedge clk);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < 9; i++) run_cycle(1'b0);
        chk("sat_count", 64'(bus_s.o_cycle_count), 64'd7);
        run_cycle(1'b1);
        chk("sat_halt_state", 64'(bus_s.o_state), 64'd2);
        chk("sat_halt_count", 64'(bus_s.o_cycle_count), 64'd7);
        run_cycle(1'b0);
        chk("drain1_state", 64'(bus_s.o_state), 64'd3);
        chk("drain1_done", 64'(bus_s.o_done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter NBITS, default 32, width of the cycle counter.
REQ-002 Parameter DRAIN, default 4, advance cycles spent draining the pipeline after a HALT is decoded (DRAIN >= 1).
REQ-003 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 i_mode_step  in  1  1 = step mode, 0 = continuous mode.
REQ-006 i_start  in  1  single-cycle pulse that starts a program run.
REQ-007 i_step  in  1  single-cycle pulse that advances one cycle in step mode.
REQ-008 i_id_rs, i_id_rt  in  5 each  source registers of the instruction in ID.
REQ-009 i_ex_mem_read  in  1  instruction in EX is a load.
REQ-010 i_ex_rt  in  5  destination register of the load in EX.
REQ-011 i_branch_taken  in  1  branch or jump resolved taken this cycle.
REQ-012 i_halt_decoded  in  1  HALT instruction present in ID.
REQ-013 o_pc_en  out  1  PC write enable.
REQ-014 o_if_id_en  out  1  IF/ID register load enable.
REQ-015 o_if_id_flush  out  1  IF/ID register loads a NOP (all zeros).
REQ-016 o_id_ex_bubble  out  1  ID/EX register loads control zeros.
REQ-017 o_pipe_en  out  1  global advance enable for the ID/EX, EX/MEM and MEM/WB registers.
REQ-018 o_state  out  2  current state: IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-019 o_done  out  1  high while in DONE.
REQ-020 o_cycle_count  out  NBITS  advance cycles executed in the current run.

Function
REQ-021 adv = !i_mode_step | i_step; adv is meaningful only in RUN and DRAIN.
REQ-022 All outputs except o_state, o_done and o_cycle_count are combinational from state and current inputs; o_state, o_done and o_cycle_count are registered.
REQ-023 IDLE: all enables, flush and bubble are 0; i_start=1 moves to RUN next edge and clears o_cycle_count to 0.
REQ-024 RUN with adv=0: all enables, flush and bubble are 0; state and counter hold.
REQ-025 RUN with adv=1: o_pipe_en=1 and the counter increments, saturating at 2^NBITS-1.
REQ-026 Load-use hazard = i_ex_mem_read & (i_ex_rt != 0) & (i_ex_rt == i_id_rs | i_ex_rt == i_id_rt).
REQ-027 RUN, adv=1, i_branch_taken=1: o_pc_en=1, o_if_id_flush=1, o_if_id_en=1, o_id_ex_bubble=0; branch takes priority over the hazard and over HALT, and a HALT in ID is discarded.
REQ-028 RUN, adv=1, no branch, hazard=1: o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1; HALT is ignored this cycle and re-evaluated on the next cycle.
REQ-029 RUN, adv=1, no branch, no hazard: o_pc_en=1, o_if_id_en=1.
REQ-030 Under REQ-029, if i_halt_decoded=1: o_pc_en=0, o_if_id_flush=1, and the block enters DRAIN with the drain counter loaded to DRAIN-1.
REQ-031 DRAIN: o_pc_en=0, with hazard and branch inputs ignored.
REQ-032 DRAIN with adv=1: o_if_id_flush=1, o_if_id_en=1 and o_pipe_en=1; the counter increments and the drain counter decrements.
REQ-033 When adv=1 and the drain counter is 0, the block moves to DONE.
REQ-034 DRAIN with adv=0: all outputs are 0 and the block holds.
REQ-035 DONE: o_done=1, all enables are 0, and o_cycle_count is frozen; i_start=1 moves to RUN and clears the counter.
REQ-036 i_start is ignored in RUN and DRAIN; i_step is ignored when i_mode_step=0.

Reset
REQ-037 i_rst=0 immediately, without waiting for a clock edge, forces state=IDLE, the counter to 0, the drain counter to 0, and every output to 0, including mid-RUN and mid-DRAIN.
REQ-038 Release of i_rst takes effect synchronously at the next rising edge; the first edge after release evaluates IDLE.

Verification
REQ-039 Continuous run: i_start, then 10 cycles with no hazard, no branch, no HALT -> o_pc_en=1 every cycle and o_cycle_count=10.
REQ-040 Load-use: i_ex_mem_read=1, i_ex_rt=5, i_id_rs=5 -> o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1 for exactly that cycle; with i_ex_rt=0 -> no stall.
REQ-041 Branch plus hazard in the same cycle -> o_if_id_flush=1, o_pc_en=1, o_id_ex_bubble=0.
REQ-042 HALT with DRAIN=4, continuous mode -> DRAIN for 4 cycles, then o_state=3 and o_done=1; o_cycle_count is frozen at the HALT cycle plus 4.
REQ-043 Step mode: 3 i_step pulses spread over 20 cycles -> o_pipe_en high for exactly 3 cycles and o_cycle_count=3.
REQ-044 i_rst=0 asserted mid-DRAIN between clock edges -> all outputs 0 and o_state=0 before the next edge; a subsequent i_start restarts with the counter at 0.
